param_sorter: RTL and testbench

- Parametrised successor to the fixed 8-entry x 4-bit sorter.
- Collects N words of width W from a single input port, one word per enter strobe, then sorts them in place.
- Sort uses odd-even transposition with early termination; ascending or descending order is selected per run.
- Presents the result as a flat bus with a done flag and supports back-to-back runs without reset.

---
 rtl/sorter_pkg.sv | 11 +
 rtl/cmp_swap.sv | 18 +
 rtl/param_sorter.sv | 128 ++++++++++++
 tb/tb_param_sorter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared types for the parametrised sorter: FSM states and sort-order constants.
package sorter_pkg;
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ASC  = 1'b0;
    localparam logic DESC = 1'b1;
endpackage

// File: rtl/cmp_swap.sv
// Compare-exchange cell: puts the pair in the requested order; combinational, no backpressure.
// Equal values pass straight through so stable runs never report a swap.
module cmp_swap
    import sorter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo_pos,
    output logic [W-1:0] hi_pos,
    output logic         swapped
);
    assign swapped = (desc == DESC) ? (a < b) : (a > b);
    assign lo_pos  = swapped ? b : a;
    assign hi_pos  = swapped ? a : b;
endmodule

// File: rtl/param_sorter.sv
// Loads N words one per enter strobe, then sorts them in place by odd-even transposition.
// Latency 2..N cycles after the last word; enter is ignored while sorting.
module param_sorter
    import sorter_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enter,
    input  logic           desc,
    input  logic [W-1:0]   IN,
    output logic           done,
    output logic           busy,
    output logic [CW-1:0]  count,
    output logic [N*W-1:0] data_out
);
    localparam int PW = (N > 2) ? $clog2(N) : 1;

    state_t        state;
    logic [W-1:0]  mem      [N];
    logic [W-1:0]  even_nxt [N];
    logic [W-1:0]  odd_nxt  [N];
    logic [W-1:0]  sort_nxt [N];
    logic [N-1:0]  sw_even;
    logic [N-1:0]  sw_odd;
    logic [PW-1:0] phase;
    logic          mode_r;
    logic          swap_prev;
    logic          swap_now;

    // Every index owns one swap bit; bits with no pair starting there stay 0.
    for (genvar i = 0; i < N; i++) begin : g_even
        if ((i % 2 == 0) && (i + 1 < N)) begin : g_pair
            cmp_swap #(.W(W)) u_cmp (
                .a(mem[i]), .b(mem[i+1]), .desc(mode_r),
                .lo_pos(even_nxt[i]), .hi_pos(even_nxt[i+1]), .swapped(sw_even[i])
            );
        end else if (i % 2 == 0) begin : g_tail
            assign even_nxt[i] = mem[i];
            assign sw_even[i]  = 1'b0;
        end else begin : g_none
            assign sw_even[i] = 1'b0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_odd
        if ((i % 2 == 1) && (i + 1 < N)) begin : g_pair
            cmp_swap #(.W(W)) u_cmp (
                .a(mem[i]), .b(mem[i+1]), .desc(mode_r),
                .lo_pos(odd_nxt[i]), .hi_pos(odd_nxt[i+1]), .swapped(sw_odd[i])
            );
        end else if ((i == 0) || (i % 2 == 1)) begin : g_hold
            assign odd_nxt[i] = mem[i];
            assign sw_odd[i]  = 1'b0;
        end else begin : g_none
            assign sw_odd[i] = 1'b0;
        end
    end

    always_comb begin
        swap_now = phase[0] ? (|sw_odd) : (|sw_even);
        for (int i = 0; i < N; i++) begin
            sort_nxt[i] = phase[0] ? odd_nxt[i] : even_nxt[i];
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < N; i++) begin
            data_out[i*W +: W] = mem[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LOAD;
            count     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            phase     <= '0;
            swap_prev <= 1'b0;
            mode_r    <= ASC;
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (enter) begin
                        for (int i = 0; i < N; i++) begin
                            if (count == CW'(i)) mem[i] <= IN;
                        end
                        count <= count + CW'(1);
                        if (count == CW'(N - 1)) begin
                            mode_r    <= desc;
                            phase     <= '0;
                            swap_prev <= 1'b0;
                            busy      <= 1'b1;
                            state     <= SORT;
                        end
                    end
                end
                SORT: begin
                    for (int i = 0; i < N; i++) mem[i] <= sort_nxt[i];
                    swap_prev <= swap_now;
                    // Two quiet phases in a row means both pairings are already in order.
                    if ((phase == PW'(N - 1)) || ((phase != '0) && !swap_now && !swap_prev)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                DONE: begin
                    if (enter) begin
                        mem[0] <= IN;
                        count  <= CW'(1);
                        done   <= 1'b0;
                        state  <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_param_sorter.sv
// Directed bench for param_sorter with a sort-by-definition reference model checked every cycle.
module tb_param_sorter;
    localparam int N  = 8;
    localparam int W  = 4;
    localparam int CW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enter = 1'b0;
    logic           desc = 1'b0;
    logic [W-1:0]   IN = '0;
    logic           done;
    logic           busy;
    logic [CW-1:0]  count;
    logic [N*W-1:0] data_out;

    param_sorter #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .enter(enter), .desc(desc), .IN(IN),
        .done(done), .busy(busy), .count(count), .data_out(data_out)
    );

    always #5 clk = ~clk;

    int             n_cmp = 0;
    int             n_err = 0;
    logic           exp_vld = 1'b0;
    logic [N*W-1:0] exp_flat = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and compare against the model whenever done is up.
    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_vld && done) begin
            check("model_data", 64'(data_out), 64'(exp_flat));
            check("model_count", 64'(count), 64'(N));
            check("model_busy", 64'(busy), 64'd0);
        end
    endtask

    function automatic logic [N*W-1:0] model(input logic [W-1:0] w[N], input logic d);
        int v[N];
        int t;
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) v[i] = int'(w[i]);
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (d ? (v[j] > v[i]) : (v[j] < v[i])) begin
                    t = v[i]; v[i] = v[j]; v[j] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(v[i]);
        return r;
    endfunction

    // Feed words s..N-1, then wait for done; optionally strobe enter or flip desc while sorting.
    task automatic run(input logic [W-1:0] w[N], input int s, input logic d,
                       input bit stray, input bit toggle, output int lat, output int bcyc);
        exp_vld = 1'b0;
        for (int i = s; i < N; i++) begin
            enter = 1'b1; IN = w[i]; desc = d;
            tick();
        end
        enter = 1'b0;
        exp_flat = model(w, d);
        exp_vld = 1'b1;
        lat = 0;
        bcyc = 0;
        while (!done && lat < N + 4) begin
            if (stray) begin
                enter = (lat % 2 == 0);
                IN = 4'hF;
            end
            if (toggle) desc = ~desc;
            if (busy) bcyc++;
            tick();
            lat++;
            if (stray && busy) check("stray_count", 64'(count), 64'(N));
        end
        enter = 1'b0;
        if (!done) check("done_timeout", 64'(done), 64'd1);
        check("latency_bound", 64'(lat <= N), 64'd1);
        tick();
        tick();
    endtask

    logic [W-1:0] v[N];
    int lat, bcyc;

    initial begin
        tick();
        tick();
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        rst = 1'b1;

        // Reset during phase 3 of a long sort.
        v = '{7, 6, 5, 4, 3, 2, 1, 0};
        for (int i = 0; i < N; i++) begin
            enter = 1'b1; IN = v[i];
            tick();
        end
        enter = 1'b0;
        tick(); tick(); tick();
        check("midsort_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_data", 64'(data_out), 64'd0);

        v = '{7, 3, 9, 1, 15, 0, 8, 2};
        run(v, 0, 1'b0, 1'b0, 1'b0, lat, bcyc);
        check("lit_asc", 64'(data_out), 64'h00000000F9873210);

        run(v, 0, 1'b1, 1'b0, 1'b1, lat, bcyc);
        check("lit_desc", 64'(data_out), 64'h000000000123789F);

        v = '{0, 1, 2, 3, 4, 5, 6, 7};
        run(v, 0, 1'b0, 1'b0, 1'b0, lat, bcyc);
        check("presorted_lat", 64'(lat), 64'd2);
        check("presorted_busy", 64'(bcyc), 64'd2);
        check("lit_presorted", 64'(data_out), 64'h0000000076543210);

        v = '{7, 6, 5, 4, 3, 2, 1, 0};
        run(v, 0, 1'b0, 1'b0, 1'b0, lat, bcyc);
        check("reversed_lat", 64'(lat), 64'd8);
        check("lit_reversed", 64'(data_out), 64'h0000000076543210);

        v = '{5, 2, 5, 2, 5, 2, 5, 2};
        run(v, 0, 1'b0, 1'b1, 1'b0, lat, bcyc);
        check("lit_dup", 64'(data_out), 64'h0000000055552222);
        check("dup_count", 64'(count), 64'd8);

        // Restart from DONE: first word lands immediately, the rest is stale until overwritten.
        exp_vld = 1'b0;
        enter = 1'b1; IN = 4'd4;
        tick();
        enter = 1'b0;
        check("restart_done", 64'(done), 64'd0);
        check("restart_count", 64'(count), 64'd1);
        check("restart_mem0", 64'(data_out[3:0]), 64'd4);
        check("restart_stale1", 64'(data_out[7:4]), 64'd2);
        tick();
        check("restart_idle_count", 64'(count), 64'd1);
        v = '{4, 14, 1, 6, 6, 11, 0, 3};
        run(v, 1, 1'b0, 1'b0, 1'b0, lat, bcyc);
        check("lit_restart", 64'(data_out), 64'h00000000EB664310);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
